// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// mem_arbiter: shares the memory controller's single cache-side port between
//   instruction fetch (port 0, read-only) and data access (port 1, read/write).
// Latency: m_re/m_we are visible the cycle after the grant edge, and the
//   requester ack follows the controller ack by one cycle.
// Backpressure: one transaction in flight. Requests are sampled only in IDLE,
//   after both handshakes have fallen, so requesters must hold re/we until acked.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   p0_*            fetch port: re, raddr, rlen in; rack, rdata out
//   p1_*            data port: re/we, addresses, lengths, wdata in; rack/wack, rdata out
//   m_*             controller side: level re/we with address/len/wdata out; rdata, rack, wack in
//   grant           one-hot current owner (bit0 = port 0, bit1 = port 1), 0 when idle
//   timeout_err     sticky flag, set when an ack wait saturates the counter
module mem_arbiter #(
    parameter int PRIO_MODE = 0,    // 0 = round-robin, 1 = port 1 always wins
    parameter int TIMEOUT_W = 16    // ack-wait counter width (>= 2)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_re,
    input  logic [31:0] p0_raddr,
    input  logic [1:0]  p0_rlen,
    output logic        p0_rack,
    output logic [31:0] p0_rdata,
    input  logic        p1_re,
    input  logic        p1_we,
    input  logic [31:0] p1_raddr,
    input  logic [31:0] p1_waddr,
    input  logic [1:0]  p1_rlen,
    input  logic [1:0]  p1_wlen,
    input  logic [31:0] p1_wdata,
    output logic        p1_rack,
    output logic        p1_wack,
    output logic [31:0] p1_rdata,
    output logic        m_re,
    output logic        m_we,
    output logic [31:0] m_raddr,
    output logic [31:0] m_waddr,
    output logic [1:0]  m_rlen,
    output logic [1:0]  m_wlen,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_rack,
    input  logic        m_wack,
    output logic [1:0]  grant,
    output logic        timeout_err
);

    typedef enum logic [1:0] {IDLE, RD, WR, REL} state_t;

    localparam logic [TIMEOUT_W-1:0] CNT_ONE = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

    state_t               r_state;
    logic                 r_last;     // 1 = port 1 won the previous round
    logic                 r_is_wr;    // current transaction is a write
    logic [TIMEOUT_W-1:0] r_cnt;

    logic                 w_p1_req;
    logic                 w_any_req;
    logic                 w_pick_p1;
    logic                 w_req_held;
    logic                 w_rel_done;
    logic [TIMEOUT_W-1:0] w_cnt_inc;
    logic                 w_cnt_max;

    assign w_p1_req  = p1_re | p1_we;
    assign w_any_req = p0_re | w_p1_req;

    always_comb begin
        w_pick_p1 = w_p1_req;
        if (p0_re && w_p1_req) begin
            // Contention: fixed priority favours port 1, round-robin favours
            // whichever port did not win last time.
            w_pick_p1 = (PRIO_MODE == 1) ? 1'b1 : ~r_last;
        end
    end

    // Release waits on the specific request that was served: a port 1 read
    // must not be held in REL by a still-pending port 1 write.
    assign w_req_held = r_is_wr  ? p1_we :
                        grant[0] ? p0_re : p1_re;
    assign w_rel_done = !m_rack && !m_wack && !w_req_held;

    assign w_cnt_inc = r_cnt + CNT_ONE;
    assign w_cnt_max = &r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_last      <= 1'b1;
            r_is_wr     <= 1'b0;
            r_cnt       <= '0;
            p0_rack     <= 1'b0;
            p0_rdata    <= '0;
            p1_rack     <= 1'b0;
            p1_wack     <= 1'b0;
            p1_rdata    <= '0;
            m_re        <= 1'b0;
            m_we        <= 1'b0;
            m_raddr     <= '0;
            m_waddr     <= '0;
            m_rlen      <= '0;
            m_wlen      <= '0;
            m_wdata     <= '0;
            grant       <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_cnt  <= '0;
                        r_last <= w_pick_p1;
                        grant  <= w_pick_p1 ? 2'b10 : 2'b01;
                        if (!w_pick_p1) begin
                            m_raddr <= p0_raddr;
                            m_rlen  <= p0_rlen;
                            m_re    <= 1'b1;
                            r_is_wr <= 1'b0;
                            r_state <= RD;
                        end else if (p1_re) begin
                            // Read goes first when port 1 asks for both.
                            m_raddr <= p1_raddr;
                            m_rlen  <= p1_rlen;
                            m_re    <= 1'b1;
                            r_is_wr <= 1'b0;
                            r_state <= RD;
                        end else begin
                            m_waddr <= p1_waddr;
                            m_wlen  <= p1_wlen;
                            m_wdata <= p1_wdata;
                            m_we    <= 1'b1;
                            r_is_wr <= 1'b1;
                            r_state <= WR;
                        end
                    end
                end

                RD: begin
                    if (!w_cnt_max) begin
                        r_cnt <= w_cnt_inc;
                        if (&w_cnt_inc) timeout_err <= 1'b1;
                    end
                    if (m_rack) begin
                        m_re <= 1'b0;
                        if (grant[0]) begin
                            p0_rdata <= m_rdata;
                            p0_rack  <= 1'b1;
                        end else begin
                            p1_rdata <= m_rdata;
                            p1_rack  <= 1'b1;
                        end
                        r_state <= REL;
                    end
                end

                WR: begin
                    if (!w_cnt_max) begin
                        r_cnt <= w_cnt_inc;
                        if (&w_cnt_inc) timeout_err <= 1'b1;
                    end
                    if (m_wack) begin
                        m_we    <= 1'b0;
                        p1_wack <= 1'b1;
                        r_state <= REL;
                    end
                end

                REL: begin
                    if (w_rel_done) begin
                        p0_rack <= 1'b0;
                        p1_rack <= 1'b0;
                        p1_wack <= 1'b0;
                        grant   <= '0;
                        r_state <= IDLE;
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port arbiter that shares the single cache-side port of the UART memory controller between requesters.
- Port 0 is instruction fetch (read-only). Port 1 is data access (read and write).
- Latches the winning request, drives the controller's level handshake (re/we held until rack/wack), returns read data to the winner, and completes the four-phase handshake on both sides before granting again.
- Sits between the fetch/LSU stages and the memory controller.

Parameters:
- PRIO_MODE, 0, 0 = round-robin between ports; 1 = fixed priority, port 1 wins.
- TIMEOUT_W, 16, width of the ack-wait counter. Timeout fires when the counter reaches all-ones.

Ports:
- clk  input  1  clock
- rst  input  1  reset
- p0_re  input  1  port 0 read request (level)
- p0_raddr  input  32  port 0 byte address
- p0_rlen  input  2  port 0 bytes-1 (0..3)
- p0_rack  output  1  port 0 read ack (level)
- p0_rdata  output  32  port 0 read data, valid while p0_rack=1
- p1_re  input  1  port 1 read request
- p1_we  input  1  port 1 write request
- p1_raddr  input  32  port 1 read address
- p1_waddr  input  32  port 1 write address
- p1_rlen  input  2  port 1 read bytes-1
- p1_wlen  input  2  port 1 write bytes-1
- p1_wdata  input  32  port 1 write data, little-endian in low bytes
- p1_rack  output  1  port 1 read ack
- p1_wack  output  1  port 1 write ack
- p1_rdata  output  32  port 1 read data
- m_re  output  1  to controller read request
- m_we  output  1  to controller write request
- m_raddr  output  32  to controller read address
- m_waddr  output  32  to controller write address
- m_rlen  output  2  to controller read length
- m_wlen  output  2  to controller write length
- m_wdata  output  32  to controller write data
- m_rdata  input  32  from controller read data
- m_rack  input  1  from controller read ack
- m_wack  input  1  from controller write ack
- grant  output  2  one-hot current owner (bit0 = port 0, bit1 = port 1); 0 when idle
- timeout_err  output  1  sticky ack-timeout flag

Behaviour:
- Reset: rst is asynchronous and active-high; clock is clk. While rst is high, all outputs are 0, state is IDLE, the last-grant bit is 1 (so port 0 wins the first round-robin tie), and the counter is 0.
- Reset mid-transaction abandons the transaction with no ack issued. The controller is reset by the same rst.
- All outputs are registered.
- States: IDLE, RD, WR, REL.
- IDLE:
  - Candidates are port 0 (p0_re), port 1 read (p1_re) and port 1 write (p1_we).
  - If p1 has both re and we asserted, the read is served first and the write in a later round.
  - PRIO_MODE=0: if both ports request, grant the port not granted last. PRIO_MODE=1: port 1 always wins.
  - On grant at edge N, latch addr/len/wdata into the m_* registers, set grant, and set last-grant.
  - At edge N, go to RD and raise m_re, or go to WR and raise m_we. m_re/m_we are visible in cycle N+1.
- RD:
  - Hold m_re.
  - On the first edge where m_rack=1: latch m_rdata into the granted pN_rdata, set pN_rack=1, clear m_re, go to REL.
  - Latency: controller ack to requester ack is 1 cycle.
- WR: same as RD, using m_wack / p1_wack / m_we. m_rdata is not latched.
- REL:
  - Stay until the controller ack (m_rack or m_wack) is 0 AND the granted requester's re/we is 0.
  - Then clear pN_rack/pN_wack and grant, and go to IDLE.
  - A new grant can be made at the earliest in the cycle after returning to IDLE.
  - A requester that drops its request early does not abort anything: the latched request completes, and the ack pulses until both conditions above hold.
- Only one m_re/m_we is ever high, and never both.
- m_* address/len/data are stable from assertion until ack.
- pN_rdata holds its value after the ack drops until the next read completes on that port.
- Timeout:
  - The counter clears on entering RD/WR and increments each cycle in RD/WR.
  - When it reaches 2^TIMEOUT_W-1, set timeout_err=1 (sticky until rst) and saturate the counter.
  - Keep waiting for the ack; the controller cannot abort a transaction.
- Requests that arrive while not in IDLE are ignored until IDLE. Requesters hold re/we until acked.

Test Plan:
- p0 read alone: p0_re=1, raddr=0x1000, rlen=3; controller acks 5 cycles after m_re with m_rdata=0xDEADBEEF -> m_raddr=0x1000, m_rlen=3, p0_rdata=0xDEADBEEF, p0_rack 1 cycle after m_rack, grant=01; returns to IDLE after p0_re and m_rack both fall.
- p1 write: waddr=0x2004, wlen=1, wdata=0x0000ABCD -> m_we=1 with identical fields, p1_wack follows m_wack, p1_rdata unchanged.
- PRIO_MODE=0, p0_re and p1_re held continuously -> grants alternate 01,10,01,10 over 4 transactions, starting with 01 after reset.
- PRIO_MODE=1, both held -> port 1 granted every round and p0 starves; p1 re+we together -> read served first, then write.
- Requester drops re before m_rack -> m_re held until m_rack; p0_rack still pulses and clears once m_rack falls.
- Controller never acks, TIMEOUT_W=4 -> timeout_err=1 after 15 cycles in RD; asserting rst mid-RD -> all outputs 0 asynchronously and timeout_err cleared.
